// File: rtl/i2c_types_pkg.sv
// rtl/i2c_types_pkg.sv - shared types and constants for the I2C slave responder
// Purpose: FSM state encoding, transfer direction type and default widths.
// Ports: none (package).
package i2c_types_pkg;

  localparam int I2C_ADDR_W_DEF = 7;
  localparam int I2C_DATA_W_DEF = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IDLE_WAIT,
    ST_IGNORE
  } i2c_state_t;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

endpackage

// File: rtl/i2c_slave_if_if.sv
// rtl/i2c_slave_if_if.sv - user-side handshake bundle of the I2C slave responder
// Purpose: groups transfer strobes, write data and read-data return path.
// Ports: xfer_start_o, xfer_rd_o, wr_data_o, wr_valid_o, rd_req_o, xfer_done_o (slave -> user),
//        rd_data_i (user -> slave). Modport slave is used by the responder, master by the user.
interface i2c_slave_if_if #(
  parameter int DW = 8
);
  logic          xfer_start_o;
  logic          xfer_rd_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_valid_o;
  logic          rd_req_o;
  logic [DW-1:0] rd_data_i;
  logic          xfer_done_o;

  modport slave (
    output xfer_start_o, xfer_rd_o, wr_data_o, wr_valid_o, rd_req_o, xfer_done_o,
    input  rd_data_i
  );

  modport master (
    input  xfer_start_o, xfer_rd_o, wr_data_o, wr_valid_o, rd_req_o, xfer_done_o,
    output rd_data_i
  );
endinterface

// File: rtl/i2c_slave_if_cond_detect.sv
// rtl/i2c_slave_if_cond_detect.sv - bus synchronizers and SCL edge / START / STOP strobes
// Purpose: 2-flop synchronizers plus previous-value registers on scl/sda; edge and
//          bus-condition strobes derived from the synchronized values only.
// Ports: clk_i, rst_i (sync, active-low), scl_i, sda_i (raw pins);
//        scl_rise_o, scl_fall_o, start_o, stop_o (1-cycle strobes), sda_s_o (synced sda).
module i2c_cond_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_s_o
);
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  // Preset to 1 so a reset looks like an idle bus and raises no false condition.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign sda_s_o    = sda_sync_q[1];
  assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
  assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;
  // scl must be high on both samples so an sda move near an scl edge is not mistaken.
  assign start_o    = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
  assign stop_o     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
endmodule

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - I2C slave responder: address match, write delivery, read shifting
// Purpose: FSM, shift registers and open-drain sda output for one I2C bus.
// Ports: clk_i, rst_i (sync, active-low), cfg_addr_i (slave address, sampled at START),
//        scl_i/sda_i (bus inputs), sda_o (open-drain: 0 or z), usr (user handshake bundle).
module i2c_slave_if
  import i2c_types_pkg::*;
#(
  parameter int I2C_ADDR_WIDTH = I2C_ADDR_W_DEF,
  parameter int I2C_DATA_WIDTH = I2C_DATA_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [I2C_ADDR_WIDTH-1:0] cfg_addr_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output wire                       sda_o,
  i2c_slave_if_if.slave             usr
);
  localparam int DW = I2C_DATA_WIDTH;

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_cond_detect u_cond (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop),
    .sda_s_o    (sda_s)
  );

  i2c_state_t                state_q;
  logic [DW-1:0]             shift_q;
  logic [DW-1:0]             rd_shift_q;
  logic [2:0]                bit_cnt_q;
  logic [I2C_ADDR_WIDTH-1:0] cfg_addr_q;
  logic                      sda_low_q;
  logic                      ack_drv_q;   // ACK phase: low is being driven, next fall ends it
  logic                      load_q;      // next fall in RD_DATA loads a fresh byte
  logic                      matched_q;
  logic                      xfer_start_q, xfer_rd_q, wr_valid_q, rd_req_q, xfer_done_q;
  logic [DW-1:0]             wr_data_q;
  logic [DW-1:0]             shift_in;

  assign shift_in = {shift_q[DW-2:0], sda_s};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      rd_shift_q   <= '0;
      bit_cnt_q    <= '0;
      cfg_addr_q   <= '0;
      sda_low_q    <= 1'b0;
      ack_drv_q    <= 1'b0;
      load_q       <= 1'b0;
      matched_q    <= 1'b0;
      xfer_start_q <= 1'b0;
      xfer_rd_q    <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_req_q     <= 1'b0;
      xfer_done_q  <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      xfer_start_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_req_q     <= 1'b0;
      xfer_done_q  <= 1'b0;
      if (start || stop) begin
        // Bus conditions override every state and release the line immediately.
        xfer_done_q <= matched_q;
        matched_q   <= 1'b0;
        sda_low_q   <= 1'b0;
        ack_drv_q   <= 1'b0;
        load_q      <= 1'b0;
        bit_cnt_q   <= '0;
        if (start) begin
          state_q    <= ST_ADDR;
          cfg_addr_q <= cfg_addr_i;
        end else begin
          state_q    <= ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_ADDR: if (scl_rise) begin
            shift_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_in[I2C_ADDR_WIDTH:1] == cfg_addr_q) begin
                matched_q    <= 1'b1;
                xfer_start_q <= 1'b1;
                xfer_rd_q    <= shift_in[0];
                rd_req_q     <= shift_in[0];
                state_q      <= ST_ADDR_ACK;
              end else begin
                state_q      <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_low_q <= 1'b1;
              ack_drv_q <= 1'b1;
            end else begin
              ack_drv_q <= 1'b0;
              if (state_q == ST_ADDR_ACK && i2c_op_t'(xfer_rd_q) == I2C_READ) begin
                // The fall ending the address ACK also puts out the first read bit.
                sda_low_q  <= ~usr.rd_data_i[DW-1];
                rd_shift_q <= usr.rd_data_i << 1;
                bit_cnt_q  <= 3'd1;
                state_q    <= ST_RD_DATA;
              end else begin
                sda_low_q  <= 1'b0;
                bit_cnt_q  <= '0;
                state_q    <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            shift_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_data_q  <= shift_in;
              wr_valid_q <= 1'b1;
              state_q    <= ST_WR_ACK;
            end
          end
          ST_RD_DATA: if (scl_fall) begin
            if (load_q) begin
              load_q     <= 1'b0;
              sda_low_q  <= ~usr.rd_data_i[DW-1];
              rd_shift_q <= usr.rd_data_i << 1;
              bit_cnt_q  <= 3'd1;
            end else if (bit_cnt_q == 3'd0) begin
              // Counter wrapped: all 8 bits have been on the bus for a full period.
              sda_low_q  <= 1'b0;
              state_q    <= ST_RD_ACK;
            end else begin
              sda_low_q  <= ~rd_shift_q[DW-1];
              rd_shift_q <= rd_shift_q << 1;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (!sda_s) begin
              rd_req_q <= 1'b1;
              load_q   <= 1'b1;
              state_q  <= ST_RD_DATA;
            end else begin
              state_q  <= ST_IDLE_WAIT;
            end
          end
          default: ;  // IDLE, IDLE_WAIT, IGNORE only leave on START/STOP
        endcase
      end
    end
  end

  assign sda_o            = sda_low_q ? 1'b0 : 1'bz;
  assign usr.xfer_start_o = xfer_start_q;
  assign usr.xfer_rd_o    = xfer_rd_q;
  assign usr.wr_data_o    = wr_data_q;
  assign usr.wr_valid_o   = wr_valid_q;
  assign usr.rd_req_o     = rd_req_q;
  assign usr.xfer_done_o  = xfer_done_q;
endmodule

// File: tb/tb_i2c_slave_if.sv
// tb/tb_i2c_slave_if.sv - directed and randomized bench for the I2C slave responder
module tb_i2c_slave_if;
  import i2c_types_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [6:0] cfg_addr = 7'h12;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic [7:0] rd_data = 8'h00;
  wire        sda_o_w;
  wire        slave_rel = (sda_o_w === 1'bz);
  wire        bus_sda = msda & slave_rel;

  int n_tests = 0, n_fail = 0;
  int n_start = 0, n_done = 0, n_wr = 0, n_rd = 0;
  logic [7:0] wr_log [64];
  logic [7:0] rd_mem [64];

  i2c_slave_if_if #(.DW(8)) usr ();
  assign usr.rd_data_i = rd_data;

  i2c_slave_if dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg_addr_i (cfg_addr),
    .scl_i      (scl),
    .sda_i      (bus_sda),
    .sda_o      (sda_o_w),
    .usr        (usr)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // User-side model: count strobes, log written bytes, answer read requests from rd_mem.
  always @(negedge clk_i) begin
    if (usr.xfer_start_o) n_start++;
    if (usr.xfer_done_o) n_done++;
    if (usr.wr_valid_o) begin
      wr_log[n_wr % 64] = usr.wr_data_o;
      n_wr++;
    end
    if (usr.rd_req_o) begin
      rd_data = rd_mem[n_rd % 64];
      n_rd++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cw(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_bit(input logic b, output logic s);
    scl = 1'b0; cw(5); msda = b; cw(5); scl = 1'b1; cw(5); s = bus_sda; cw(5);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i], b);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, b);
      rx[i] = b;
    end
    send_bit(nack, b);
  endtask

  task automatic bus_start();
    msda = 1'b0; cw(10);
  endtask

  task automatic bus_rstart();
    scl = 1'b0; cw(5); msda = 1'b1; cw(5); scl = 1'b1; cw(5); msda = 1'b0; cw(10);
  endtask

  task automatic bus_stop();
    scl = 1'b0; cw(5); msda = 1'b0; cw(5); scl = 1'b1; cw(5); msda = 1'b1; cw(10);
  endtask

  // Whole write transfer: address ACK, every byte ACKed, each byte delivered once, one done.
  task automatic do_write(input logic [6:0] a, input int n, input logic [7:0] d [64]);
    int w0, s0, d0;
    logic ack;
    w0 = n_wr; s0 = n_start; d0 = n_done;
    cfg_addr = a;
    bus_start();
    send_byte({a, 1'b0}, ack);
    check("wr_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], ack);
      check("wr_byte_ack", ack, 0);
    end
    bus_stop();
    check("wr_count", n_wr - w0, n);
    for (int i = 0; i < n; i++) check("wr_data", wr_log[(w0 + i) % 64], d[i]);
    check("wr_start_cnt", n_start - s0, 1);
    check("wr_done_cnt", n_done - d0, 1);
    check("wr_xfer_rd", usr.xfer_rd_o, 0);
  endtask

  // Whole read transfer: master ACKs all but the last byte, then NACKs and stops.
  task automatic do_read(input logic [6:0] a, input int n, input logic [7:0] d [64]);
    int r0, s0, d0;
    logic ack;
    logic [7:0] rx;
    r0 = n_rd; s0 = n_start; d0 = n_done;
    for (int i = 0; i < n; i++) rd_mem[(r0 + i) % 64] = d[i];
    cfg_addr = a;
    bus_start();
    send_byte({a, 1'b1}, ack);
    check("rd_addr_ack", ack, 0);
    check("rd_xfer_rd", usr.xfer_rd_o, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, rx);
      check("rd_byte", rx, d[i]);
    end
    cw(3);
    check("rd_rel_after_nack", slave_rel, 1);
    bus_stop();
    check("rd_rel_after_stop", slave_rel, 1);
    check("rd_req_cnt", n_rd - r0, n);
    check("rd_start_cnt", n_start - s0, 1);
    check("rd_done_cnt", n_done - d0, 1);
  endtask

  initial begin
    logic [7:0] buf8 [64];
    logic ack, b;
    logic [7:0] rx;
    int s0, d0, w0, r0;

    // Reset and idle bus
    cw(3);
    check("rst_sda", slave_rel, 1);
    check("rst_start", usr.xfer_start_o, 0);
    check("rst_done", usr.xfer_done_o, 0);
    check("rst_wrv", usr.wr_valid_o, 0);
    check("rst_rdreq", usr.rd_req_o, 0);
    check("rst_wrdata", usr.wr_data_o, 0);
    check("rst_xfer_rd", usr.xfer_rd_o, 0);
    rst_i = 1'b1;
    cw(50);
    check("idle_events", n_start + n_done + n_wr + n_rd, 0);
    check("idle_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Write 0x00..0x1F to 0x12
    for (int i = 0; i < 32; i++) buf8[i] = 8'(i);
    do_write(7'h12, 32, buf8);

    // Read 100..131 from 0x12
    for (int i = 0; i < 32; i++) buf8[i] = 8'(100 + i);
    do_read(7'h12, 32, buf8);

    // Address mismatch
    s0 = n_start; d0 = n_done; w0 = n_wr;
    cfg_addr = 7'h12;
    bus_start();
    send_byte(8'h22, ack);
    check("mm_nack", ack, 1);
    check("mm_state", 32'(dut.state_q), 32'(ST_IGNORE));
    send_byte(8'h55, ack);
    check("mm_data_nack", ack, 1);
    check("mm_state2", 32'(dut.state_q), 32'(ST_IGNORE));
    bus_stop();
    check("mm_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("mm_start", n_start - s0, 0);
    check("mm_wr", n_wr - w0, 0);
    check("mm_done", n_done - d0, 0);

    // Repeated START: write 0x40, then Sr and read one byte
    s0 = n_start; d0 = n_done; w0 = n_wr; r0 = n_rd;
    rd_mem[r0 % 64] = 8'hA5;
    bus_start();
    send_byte(8'h24, ack);
    check("sr_wr_ack", ack, 0);
    send_byte(8'h40, ack);
    check("sr_byte_ack", ack, 0);
    check("sr_wr_data", wr_log[w0 % 64], 8'h40);
    bus_rstart();
    check("sr_done", n_done - d0, 1);
    send_byte(8'h25, ack);
    check("sr_rd_ack", ack, 0);
    check("sr_xfer_rd", usr.xfer_rd_o, 1);
    read_byte(1'b1, rx);
    check("sr_rd_byte", rx, 8'hA5);
    bus_stop();
    check("sr_rdreq", n_rd - r0, 1);
    check("sr_starts", n_start - s0, 2);
    check("sr_done_total", n_done - d0, 2);

    // Randomized transfers against the byte-level model
    for (int it = 0; it < 4; it++) begin
      logic [6:0] a;
      int n;
      a = 7'($urandom_range(1, 127));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) buf8[i] = 8'($urandom);
      if (it % 2 == 0) do_write(a, n, buf8);
      else do_read(a, n, buf8);
    end

    // Reset in the middle of a read byte
    d0 = n_done; r0 = n_rd;
    rd_mem[r0 % 64] = 8'd100;  // 0110_0100: the 4th bit drives low
    cfg_addr = 7'h12;
    bus_start();
    send_byte(8'h25, ack);
    check("mr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, b);
    scl = 1'b0; cw(8);
    check("mr_driving_low", slave_rel, 0);
    rst_i = 1'b0;
    cw(1);
    check("mr_sda_rel", slave_rel, 1);
    check("mr_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_i = 1'b1;
    cw(5); scl = 1'b1; cw(5); msda = 1'b1; cw(10);
    check("mr_no_done", n_done - d0, 0);
    check("mr_state_after", 32'(dut.state_q), 32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
